rom_page_loader: RTL and testbench

- Parametrised successor to the boot-time ROM download path in the CPC top level.
- Accepts the hps_io ioctl byte stream and maps each 16 KB (2^PAGE_W) page of the image to a configurable SDRAM page address and bank (model). Writes through a small FIFO, paced by the SDRAM refresh/clock-reference strobe ce_ref.
- Adds over the current path: N banks, a parametric page map, FIFO buffering instead of a per-byte stall, and overflow detection, completion signalling and a loaded-page mask.
- Sits between hps_io and zsdram; its outputs are muxed onto the zsdram port while the system is in reset.

---
 rtl/rom_loader_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/rom_page_loader.sv | 177 +++++++++++++++++
 tb/tb_rom_page_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types for the ROM page loader: FIFO entry layout, write-engine states
// and the default page map for the CPC image layout.
package rom_loader_pkg;

  localparam int LD_ADDR_W = 23;
  localparam int LD_BANK_W = 1;
  localparam int LD_MAP_W  = 9;
  localparam int LD_PAGES  = 3;

  // Entry fields are sized for the default SDRAM geometry.
  typedef struct packed {
    logic [LD_ADDR_W-1:0] addr;
    logic [LD_BANK_W-1:0] bank;
    logic [7:0]           data;
  } rom_entry_t;

  typedef enum logic {
    ENG_IDLE  = 1'b0,
    ENG_WRITE = 1'b1
  } eng_state_t;

  function automatic logic [LD_PAGES*LD_MAP_W-1:0] default_page_map();
    return {9'h107, 9'h100, 9'h000};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_page_loader.sv
// Maps the hps_io ROM byte stream onto SDRAM pages/banks and writes it through
// a small FIFO, one byte per two ce_ref periods.
module rom_page_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W         = LD_ADDR_W,
  parameter int PAGE_W         = 14,
  parameter int PAGES_PER_BANK = LD_PAGES,
  parameter int NUM_BANKS      = 2,
  parameter int BANK_W         = LD_BANK_W,
  parameter logic [PAGES_PER_BANK*(ADDR_W-PAGE_W)-1:0] PAGE_MAP = default_page_map(),
  parameter int DEPTH          = 4
) (
  input  logic                                clk_sys,
  input  logic                                reset,
  input  logic                                ce_ref,
  input  logic                                dl_active,
  input  logic                                ioctl_wr,
  input  logic [24:0]                         ioctl_addr,
  input  logic [7:0]                          ioctl_dout,
  output logic                                ioctl_wait,
  output logic                                mem_we,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [BANK_W-1:0]                   mem_bank,
  output logic [7:0]                          mem_din,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow,
  output logic [NUM_BANKS*PAGES_PER_BANK-1:0] page_mask,
  output eng_state_t                          dbg_state
);

  localparam int MAP_W  = ADDR_W - PAGE_W;
  localparam int P_W    = 25 - PAGE_W;
  localparam int NPAGES = NUM_BANKS * PAGES_PER_BANK;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int ENT_W  = $bits(rom_entry_t);

  logic [P_W-1:0]    page;
  logic [NPAGES-1:0] page_hit;
  logic [BANK_W-1:0] dec_bank;
  logic [MAP_W-1:0]  dec_base;
  logic              in_range;

  // Constant compare chain stands in for page / PAGES_PER_BANK and page % PAGES_PER_BANK.
  always_comb begin
    page     = ioctl_addr[24:PAGE_W];
    page_hit = '0;
    dec_bank = '0;
    dec_base = '0;
    in_range = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int s = 0; s < PAGES_PER_BANK; s++) begin
        if (page == P_W'(b * PAGES_PER_BANK + s)) begin
          page_hit[b*PAGES_PER_BANK+s] = 1'b1;
          dec_bank = BANK_W'(b);
          dec_base = PAGE_MAP[s*MAP_W +: MAP_W];
          in_range = 1'b1;
        end
      end
    end
  end

  rom_entry_t       push_entry, head;
  logic [ENT_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, count_nxt;
  logic             wr_req, push_ok, pop_req;
  eng_state_t       state_q;

  always_comb begin
    push_entry.addr = LD_ADDR_W'({dec_base, ioctl_addr[PAGE_W-1:0]});
    push_entry.bank = LD_BANK_W'(dec_bank);
    push_entry.data = ioctl_dout;
  end

  assign head    = rom_entry_t'(fifo_rdata);
  assign wr_req  = dl_active & ioctl_wr & in_range;
  assign push_ok = wr_req & ~fifo_full;
  assign pop_req = (state_q == ENG_WRITE) & ce_ref;
  assign count_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(pop_req);

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .reset_i (reset),
    .push_i  (push_ok),
    .pop_i   (pop_req),
    .wdata_i (push_entry),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BANK_W-1:0] mem_bank_q;
  logic [7:0]        mem_din_q;

  // The head stays in the FIFO until the write period ends, so a reset drops it too.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ENG_IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_bank_q <= '0;
      mem_din_q  <= '0;
    end else begin
      case (state_q)
        ENG_IDLE: begin
          if (ce_ref && !fifo_empty) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= ADDR_W'(head.addr);
            mem_bank_q <= BANK_W'(head.bank);
            mem_din_q  <= head.data;
            state_q    <= ENG_WRITE;
          end
        end
        ENG_WRITE: begin
          if (ce_ref) begin
            mem_we_q <= 1'b0;
            state_q  <= ENG_IDLE;
          end
        end
        default: state_q <= ENG_IDLE;
      endcase
    end
  end

  logic              dl_q, pend_q, done_q, ovf_q, wait_q;
  logic              pend_d, done_d, ovf_d, wait_d, pend_now, dl_rise, dl_fall;
  logic [NPAGES-1:0] mask_q, mask_d;

  always_comb begin
    dl_rise  = dl_active & ~dl_q;
    dl_fall  = ~dl_active & dl_q;
    pend_now = (pend_q | dl_fall) & ~dl_rise;
    done_d   = pend_now & ~dl_active & fifo_empty & (state_q == ENG_IDLE);
    pend_d   = pend_now & ~done_d;
    mask_d   = (dl_rise ? '0 : mask_q) | (push_ok ? page_hit : '0);
    ovf_d    = (ovf_q & ~dl_rise) | (wr_req & fifo_full);
    wait_d   = (count_nxt == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q   <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      wait_q <= 1'b0;
      mask_q <= '0;
    end else begin
      dl_q   <= dl_active;
      pend_q <= pend_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      wait_q <= wait_d;
      mask_q <= mask_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_bank   = mem_bank_q;
  assign mem_din    = mem_din_q;
  assign busy       = dl_active | ~fifo_empty | (state_q != ENG_IDLE);
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign page_mask  = mask_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_page_loader.sv
// Directed bench for rom_page_loader: decode, FIFO backpressure/overflow,
// write pacing, done signalling and mid-download reset.
module tb_rom_page_loader;
  import rom_loader_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset, ce_ref, dl_active, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait, mem_we, busy, done, overflow;
  logic [22:0] mem_addr;
  logic [0:0]  mem_bank;
  logic [7:0]  mem_din;
  logic [5:0]  page_mask;
  eng_state_t  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_writes = 0;
  int done_cnt = 0;
  int stab_err = 0;
  int writes_at_done = -1;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          wr_ts[$];
  logic        prev_we = 1'b0;
  logic [31:0] prev_val = '0;

  always #5 clk_sys = ~clk_sys;

  rom_page_loader dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_ref     (ce_ref),
    .dl_active  (dl_active),
    .ioctl_wr   (ioctl_wr),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .ioctl_wait (ioctl_wait),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_bank   (mem_bank),
    .mem_din    (mem_din),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .page_mask  (page_mask),
    .dbg_state  (dbg_state)
  );

  // ce_ref: one clk_sys cycle in every eight.
  initial begin : ce_gen
    int k;
    k = 0;
    ce_ref = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      ce_ref = (k == 7);
      k = (k + 1) % 8;
    end
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (mem_we) begin
      if (!prev_we) begin
        obs_q.push_back({mem_bank, mem_addr, mem_din});
        wr_ts.push_back(cyc);
        n_writes <= n_writes + 1;
      end else if ({mem_bank, mem_addr, mem_din} != prev_val) begin
        stab_err <= stab_err + 1;
      end
    end
    prev_we  <= mem_we;
    prev_val <= {mem_bank, mem_addr, mem_din};
    if (done) begin
      done_cnt       <= done_cnt + 1;
      writes_at_done <= n_writes;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int t;
    t = 0;
    while (n_writes < n && t < budget) begin
      tick(1);
      t++;
    end
    check("write_count", n_writes, n);
  endtask

  task automatic wait_done(input int n, input int budget);
    int t;
    t = 0;
    while (done_cnt < n && t < budget) begin
      tick(1);
      t++;
    end
    check("done_count", done_cnt, n);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  // Independent decode model: {bank, sdram_addr, data}.
  function automatic logic [31:0] model(input logic [24:0] a, input logic [7:0] d);
    logic [8:0] map [3];
    int p;
    map[0] = 9'h000;
    map[1] = 9'h100;
    map[2] = 9'h107;
    p = int'(a >> 14);
    return {1'(p / 3), map[p % 3], a[13:0], d};
  endfunction

  initial begin
    int sz;
    int stalls;
    logic [24:0] a;
    logic [7:0]  d;

    reset = 1'b1; dl_active = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    tick(4);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_mask", 32'(page_mask), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    tick(2);

    // Test 1: page 0 byte
    dl_active = 1'b1;
    tick(2);
    check("dl_busy", 32'(busy), 32'd1);
    exp_q.push_back(32'h0000_00A5);
    send(25'h0000000, 8'hA5);
    wait_writes(1, 64);
    compare_stream("t1_write");
    check("t1_mask", 32'(page_mask), 32'h01);

    // Test 2: bank 1 slots 1 and 2
    exp_q.push_back(32'hC000_053C);
    exp_q.push_back(32'hC1C0_055A);
    send(25'h0010005, 8'h3C);
    send(25'h0014005, 8'h5A);
    wait_writes(3, 128);
    compare_stream("t2_write");
    check("t2_mask", 32'(page_mask), 32'h31);

    // Test 3: page 6 is beyond the last bank
    send(25'h0018000, 8'h77);
    tick(40);
    check("t3_no_write", n_writes, 3);
    check("t3_overflow", 32'(overflow), 32'd0);
    check("t3_mask", 32'(page_mask), 32'h31);
    check("t3_wait", 32'(ioctl_wait), 32'd0);

    dl_active = 1'b0;
    wait_done(1, 64);
    tick(20);
    check("d1_single", done_cnt, 1);
    check("d1_busy", 32'(busy), 32'd0);

    // Test 4: burst of six ignoring ioctl_wait
    dl_active = 1'b1;
    tick(2);
    check("t4_mask_clr", 32'(page_mask), 32'd0);
    for (int i = 0; i < 6; i++) begin
      send(25'h100 + 25'(i), 8'h10 + 8'(i));
      if (i == 2) check("t4_wait_3", 32'(ioctl_wait), 32'd0);
      if (i == 3) check("t4_wait_4", 32'(ioctl_wait), 32'd1);
    end
    check("t4_overflow", 32'(overflow), 32'd1);
    exp_q.push_back(32'h0001_0010);
    exp_q.push_back(32'h0001_0111);
    exp_q.push_back(32'h0001_0212);
    exp_q.push_back(32'h0001_0313);
    wait_writes(7, 200);
    compare_stream("t4_write");
    sz = wr_ts.size();
    for (int j = 1; j < 4; j++)
      check("t4_spacing", wr_ts[sz-4+j] - wr_ts[sz-5+j], 16);
    tick(40);
    check("t4_exact4", n_writes, 7);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    check("t4_mask", 32'(page_mask), 32'h01);
    dl_active = 1'b0;
    wait_done(2, 100);

    // Test 5: 100 bytes with flow control
    dl_active = 1'b1;
    tick(2);
    check("t5_ovf_clr", 32'(overflow), 32'd0);
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      int t;
      t = 0;
      while (ioctl_wait && t < 100) begin
        tick(1);
        t++;
      end
      if (t >= 100) stalls++;
      a = {11'(i % 6), 14'(i * 97)};
      d = 8'(i * 7 + 3);
      exp_q.push_back(model(a, d));
      send(a, d);
    end
    check("t5_no_stall_timeout", stalls, 0);
    dl_active = 1'b0;
    wait_done(3, 4000);
    check("t5_writes_at_done", writes_at_done, 107);
    compare_stream("t5_write");
    check("t5_mask", 32'(page_mask), 32'h3F);
    check("t5_overflow", 32'(overflow), 32'd0);
    tick(30);
    check("t5_done_once", done_cnt, 3);
    check("t5_busy", 32'(busy), 32'd0);

    // Test 6: reset with an in-flight write and three queued bytes
    dl_active = 1'b1;
    for (int i = 0; i < 4; i++) send(25'h2000 + 25'(i), 8'hC0 + 8'(i));
    begin
      int t;
      t = 0;
      while (!mem_we && t < 32) begin
        tick(1);
        t++;
      end
    end
    check("t6_inflight", 32'(mem_we), 32'd1);
    exp_q.push_back(32'h0020_00C0);
    reset = 1'b1;
    dl_active = 1'b0;
    tick(1);
    check("t6_we_drop", 32'(mem_we), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(100);
    check("t6_no_more", n_writes, 108);
    check("t6_no_done", done_cnt, 3);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_wait", 32'(ioctl_wait), 32'd0);
    check("t6_addr_rst", 32'(mem_addr), 32'd0);
    compare_stream("t6_write");
    check("stable_during_we", stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
